// File: rtl/arc4_pkg.sv
// Shared definitions for the ARC4 key cracker: widths, memory depth,
// printable-ASCII bounds, FSM state encodings and a printable test helper.
package arc4_pkg;

   localparam int KEY_W     = 24;
   localparam int MEM_DEPTH = 256;

   localparam logic [7:0]       PRINT_LO = 8'h20;
   localparam logic [7:0]       PRINT_HI = 8'h7E;
   localparam logic [KEY_W-1:0] KEY_MAX  = '1;

   // FSM state encodings. K_* states sequence the key schedule, P_* states
   // sequence keystream generation, decryption and the printable check.
   typedef logic [3:0] state_t;
   localparam state_t ST_IDLE  = 4'd0;
   localparam state_t ST_INIT  = 4'd1;
   localparam state_t ST_K_RDI = 4'd2;
   localparam state_t ST_K_RDJ = 4'd3;
   localparam state_t ST_K_WRI = 4'd4;
   localparam state_t ST_K_WRJ = 4'd5;
   localparam state_t ST_P_RDI = 4'd6;
   localparam state_t ST_P_RDJ = 4'd7;
   localparam state_t ST_P_WRI = 4'd8;
   localparam state_t ST_P_WRJ = 4'd9;
   localparam state_t ST_P_RDT = 4'd10;
   localparam state_t ST_P_CHK = 4'd11;

   function automatic logic is_printable(input logic [7:0] b);
      return (b >= PRINT_LO) && (b <= PRINT_HI);
   endfunction

endpackage

// File: rtl/arc4_crack_if.sv
// Host-side signal bundle of arc4_crack.
//   en/rdy            start handshake
//   key/key_valid     search result
//   ct_addr/ct_rddata external ciphertext RAM read port (1-cycle latency)
//   msg_length        ciphertext byte count, sampled at start
//   key_crack         0 = search from key 0, 1 = resume from key+1
//   pt_addr_db/pt_rddata debug read port into the plaintext memory
// master: the host/testbench side; slave: the cracker.
interface arc4_crack_if;

   logic                       en;
   logic                       rdy;
   logic [arc4_pkg::KEY_W-1:0] key;
   logic                       key_valid;
   logic [7:0]                 ct_addr;
   logic [7:0]                 ct_rddata;
   logic [7:0]                 msg_length;
   logic                       key_crack;
   logic [7:0]                 pt_addr_db;
   logic [7:0]                 pt_rddata;

   modport master (
      output en, ct_rddata, msg_length, key_crack, pt_addr_db,
      input  rdy, key, key_valid, ct_addr, pt_rddata
   );

   modport slave (
      input  en, ct_rddata, msg_length, key_crack, pt_addr_db,
      output rdy, key, key_valid, ct_addr, pt_rddata
   );

endinterface

// File: rtl/arc4_sram.sv
// 256x8 synchronous RAM: one read/write port (a) plus a read-only port (b).
// Both reads are registered (data valid the cycle after the address).
//   clk              clock
//   addr/we/wdata    port a address, write enable, write data
//   rdata            port a read data (old contents on a write cycle)
//   addr_b/rdata_b   port b read address and read data
module arc4_sram
   import arc4_pkg::*;
(
   input  logic       clk,
   input  logic [7:0] addr,
   input  logic       we,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   input  logic [7:0] addr_b,
   output logic [7:0] rdata_b
);

   logic [7:0] mem [MEM_DEPTH];

   // NOTE: the array has no reset; it maps onto RAM macros, and every S or
   // plaintext location is written before it is read for each key.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata   <= mem[addr];
      rdata_b <= mem[addr_b];
   end

endmodule

// File: rtl/arc4_crack.sv
// ARC4 brute-force key cracker. Tries 24-bit keys in ascending order, decrypts
// the external ciphertext with each, and stops at the first key whose
// plaintext is entirely printable ASCII (or after key 0xFFFFFF fails).
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    arc4_crack_if.slave (handshake, result, ct RAM, control, debug)
module arc4_crack
   import arc4_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   arc4_crack_if.slave  bus
);

   state_t           state;
   logic [7:0]       i, j;
   logic [1:0]       kidx;     // i mod 3 during the key schedule
   logic [7:0]       si, sj;   // S[i] and S[j] captured for the swap
   logic [7:0]       len;
   logic             armed;    // re-armed only once en has been seen low
   logic             rdy;
   logic             key_valid;
   logic [KEY_W-1:0] key;
   logic [7:0]       ct_addr;  // doubles as the plaintext byte index k

   logic [7:0] s_addr, s_wdata, s_rdata;
   logic       s_we;
   logic       pt_we;
   logic [7:0] kb, j_ksa, j_prga, i_inc, pt_byte, t_addr;
   logic       start;
   logic [KEY_W-1:0] first_key;

   assign bus.rdy       = rdy;
   assign bus.key_valid = key_valid;
   assign bus.key       = key;
   assign bus.ct_addr   = ct_addr;

   // A held en starts only one search: the request must drop before it counts
   // again. Reset leaves the cracker armed so en held across release works.
   assign start     = bus.en && rdy && armed;
   assign first_key = !bus.key_crack ? '0 :
                      (key == KEY_MAX) ? key : key + 1'b1;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned
      // and infers a latch.
      s_addr  = '0;
      s_we    = 1'b0;
      s_wdata = '0;
      pt_we   = 1'b0;
      unique case (kidx)
         2'd0:    kb = key[23:16];
         2'd1:    kb = key[15:8];
         default: kb = key[7:0];
      endcase
      j_ksa   = j + s_rdata + kb;
      j_prga  = j + s_rdata;
      i_inc   = i + 8'd1;
      t_addr  = si + sj;
      pt_byte = s_rdata ^ bus.ct_rddata;
      case (state)
         ST_INIT: begin
            s_addr  = i;
            s_we    = 1'b1;
            s_wdata = i;
         end
         ST_K_RDI: s_addr = i;
         ST_K_RDJ: s_addr = j_ksa;
         ST_P_RDI: s_addr = i_inc;
         ST_P_RDJ: s_addr = j_prga;
         ST_K_WRI, ST_P_WRI: begin  // S[i] <= S[j], just read
            s_addr  = i;
            s_we    = 1'b1;
            s_wdata = s_rdata;
         end
         ST_K_WRJ, ST_P_WRJ: begin  // S[j] <= old S[i]
            s_addr  = j;
            s_we    = 1'b1;
            s_wdata = si;
         end
         ST_P_RDT: s_addr = t_addr;
         ST_P_CHK: pt_we = 1'b1;
         default: ;
      endcase
   end

   arc4_sram u_s_mem (
      .clk     (clk),
      .addr    (s_addr),
      .we      (s_we),
      .wdata   (s_wdata),
      .rdata   (s_rdata),
      .addr_b  (8'd0),
      .rdata_b ()
   );

   arc4_sram u_pt_mem (
      .clk     (clk),
      .addr    (ct_addr),
      .we      (pt_we),
      .wdata   (pt_byte),
      .rdata   (),
      .addr_b  (bus.pt_addr_db),
      .rdata_b (bus.pt_rddata)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         i         <= '0;
         j         <= '0;
         kidx      <= '0;
         si        <= '0;
         sj        <= '0;
         len       <= '0;
         armed     <= 1'b1;
         rdy       <= 1'b1;
         key_valid <= 1'b0;
         key       <= '0;
         ct_addr   <= '0;
      end else begin
         if (!bus.en) begin
            armed <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (start) begin
                  armed     <= 1'b0;
                  rdy       <= 1'b0;
                  key_valid <= 1'b0;
                  key       <= first_key;
                  len       <= bus.msg_length;
                  i         <= '0;
                  ct_addr   <= '0;
                  state     <= ST_INIT;
               end
            end
            ST_INIT: begin
               if (len == 8'd0) begin
                  // Empty message: the first key is trivially printable.
                  rdy       <= 1'b1;
                  key_valid <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  i <= i_inc;
                  if (i == 8'hFF) begin
                     j     <= '0;
                     kidx  <= '0;
                     state <= ST_K_RDI;
                  end
               end
            end
            ST_K_RDI: state <= ST_K_RDJ;
            ST_K_RDJ: begin
               si    <= s_rdata;
               j     <= j_ksa;
               state <= ST_K_WRI;
            end
            ST_K_WRI: state <= ST_K_WRJ;
            ST_K_WRJ: begin
               i    <= i_inc;
               kidx <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
               if (i == 8'hFF) begin
                  j     <= '0;
                  state <= ST_P_RDI;
               end else begin
                  state <= ST_K_RDI;
               end
            end
            ST_P_RDI: begin
               i     <= i_inc;
               state <= ST_P_RDJ;
            end
            ST_P_RDJ: begin
               si    <= s_rdata;
               j     <= j_prga;
               state <= ST_P_WRI;
            end
            ST_P_WRI: begin
               sj    <= s_rdata;
               state <= ST_P_WRJ;
            end
            ST_P_WRJ: state <= ST_P_RDT;
            ST_P_RDT: state <= ST_P_CHK;
            ST_P_CHK: begin
               if (!is_printable(pt_byte)) begin
                  if (key == KEY_MAX) begin
                     rdy   <= 1'b1;
                     state <= ST_IDLE;
                  end else begin
                     key     <= key + 1'b1;
                     i       <= '0;
                     ct_addr <= '0;
                     state   <= ST_INIT;
                  end
               end else if (ct_addr == len - 8'd1) begin
                  rdy       <= 1'b1;
                  key_valid <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  ct_addr <= ct_addr + 8'd1;
                  state   <= ST_P_RDI;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_arc4_crack.sv
// Self-checking bench for arc4_crack: a reference ARC4 model encrypts a known
// printable plaintext under a chosen key; the cracker must recover that key
// and the plaintext within the cycle budget.
module tb_arc4_crack;
   import arc4_pkg::*;

   typedef logic [7:0] bytes_t [256];

   typedef struct {
      logic [23:0] enc_key;
      logic [7:0]  len;
      logic        crack;
      int          budget;
      logic [23:0] exp_key;
      logic        exp_valid;
   } vec_t;

   typedef struct {
      logic [23:0] key;
      logic        valid;
      int          len;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   arc4_crack_if bus ();

   arc4_crack dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   bytes_t ct_mem;
   bytes_t pt_ref;
   exp_t   sb_q[$];
   int     n_pass = 0;
   int     n_total = 0;

   always @(posedge clk) bus.ct_rddata <= ct_mem[bus.ct_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Textbook ARC4 with a 3-byte key; XORs the keystream onto din.
   function automatic bytes_t rc4_xor(input logic [23:0] k, input int len, input bytes_t din);
      bytes_t s;
      bytes_t dout;
      logic [7:0] kb [3];
      logic [7:0] a, b, tmp;
      kb[0] = k[23:16];
      kb[1] = k[15:8];
      kb[2] = k[7:0];
      for (int x = 0; x < 256; x++) begin
         s[x]    = 8'(x);
         dout[x] = 8'h00;
      end
      b = 8'h00;
      for (int x = 0; x < 256; x++) begin
         b    = b + s[x] + kb[x % 3];
         tmp  = s[x];
         s[x] = s[b];
         s[b] = tmp;
      end
      a = 8'h00;
      b = 8'h00;
      for (int n = 0; n < len; n++) begin
         a       = a + 8'd1;
         b       = b + s[a];
         tmp     = s[a];
         s[a]    = s[b];
         s[b]    = tmp;
         tmp     = s[a] + s[b];
         dout[n] = s[tmp] ^ din[n];
      end
      return dout;
   endfunction

   task automatic do_search(input string tag, input logic crack, input logic [7:0] len,
                            input int budget, input logic [23:0] exp_key, input logic exp_valid);
      exp_t e;
      exp_t got;
      int   cycles;
      e.key   = exp_key;
      e.valid = exp_valid;
      e.len   = int'(len);
      @(negedge clk);
      bus.msg_length = len;
      bus.key_crack  = crack;
      bus.en         = 1'b1;
      sb_q.push_back(e);
      @(negedge clk);
      bus.en = 1'b0;
      check({tag, "_rdy_fall"}, 32'(bus.rdy), 32'd0);
      cycles = 1;
      while (!bus.rdy && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
      check({tag, "_done_in_budget"}, 32'(bus.rdy), 32'd1);
      got = sb_q.pop_front();
      check({tag, "_key"}, 32'(bus.key), 32'(got.key));
      check({tag, "_key_valid"}, 32'(bus.key_valid), 32'(got.valid));
      for (int a = 0; a < got.len; a++) begin
         bus.pt_addr_db = 8'(a);
         @(negedge clk);
         check({tag, "_pt"}, 32'(bus.pt_rddata), 32'(pt_ref[a]));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rdy"}, 32'(bus.rdy), 32'd1);
      check({tag, "_key_valid"}, 32'(bus.key_valid), 32'd0);
      check({tag, "_key"}, 32'(bus.key), 32'd0);
      check({tag, "_ct_addr"}, 32'(bus.ct_addr), 32'd0);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs [4];
      int   busy;
      int   prev_key;
      bit   mono_ok;

      for (int n = 0; n < 256; n++) pt_ref[n] = 8'h20 + 8'((n * 7 + 3) % 95);

      vecs[0] = '{enc_key: 24'h000000, len: 8'h35, crack: 1'b0, budget: 1700,
                  exp_key: 24'h000000, exp_valid: 1'b1};
      vecs[1] = '{enc_key: 24'h000002, len: 8'h35, crack: 1'b0, budget: 150000,
                  exp_key: 24'h000002, exp_valid: 1'b1};
      vecs[2] = '{enc_key: 24'h000002, len: 8'h00, crack: 1'b0, budget: 300,
                  exp_key: 24'h000000, exp_valid: 1'b1};
      vecs[3] = '{enc_key: 24'h000005, len: 8'h35, crack: 1'b0, budget: 20000,
                  exp_key: 24'h000005, exp_valid: 1'b1};

      // Reset with en held high, then one search on an empty message.
      bus.en         = 1'b1;
      bus.msg_length = 8'h00;
      bus.key_crack  = 1'b0;
      bus.pt_addr_db = 8'h00;
      ct_mem         = pt_ref;
      rst_n          = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      busy  = 0;
      repeat (25) begin
         @(negedge clk);
         if (!bus.rdy) busy++;
      end
      bus.en = 1'b0;
      repeat (3) @(negedge clk);
      check("held_en_single_search", 32'(busy), 32'd1);
      check("held_en_key", 32'(bus.key), 32'd0);
      check("held_en_key_valid", 32'(bus.key_valid), 32'd1);

      // Table-driven searches.
      for (int v = 0; v < 4; v++) begin
         ct_mem = rc4_xor(vecs[v].enc_key, int'(vecs[v].len), pt_ref);
         do_search($sformatf("vec%0d", v), vecs[v].crack, vecs[v].len,
                   vecs[v].budget, vecs[v].exp_key, vecs[v].exp_valid);
      end

      // Resume after finding key 2: search restarts at 3 and only counts up.
      ct_mem = rc4_xor(24'h000002, 8'h35, pt_ref);
      do_search("resume_base", 1'b0, 8'h35, 150000, 24'h000002, 1'b1);
      @(negedge clk);
      bus.key_crack = 1'b1;
      bus.en        = 1'b1;
      @(negedge clk);
      bus.en = 1'b0;
      check("resume_first_key", 32'(bus.key), 32'h3);
      check("resume_key_valid_clear", 32'(bus.key_valid), 32'd0);
      prev_key = 3;
      mono_ok  = 1'b1;
      repeat (6000) begin
         @(negedge clk);
         if (int'(bus.key) < prev_key || int'(bus.key) > prev_key + 1) mono_ok = 1'b0;
         prev_key = int'(bus.key);
      end
      check("resume_monotonic", 32'(mono_ok), 32'd1);
      check("resume_advanced", 32'(prev_key > 3), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Reset in the middle of key 1's key schedule, then a clean rerun.
      @(negedge clk);
      bus.key_crack  = 1'b0;
      bus.msg_length = 8'h35;
      bus.en         = 1'b1;
      @(negedge clk);
      bus.en = 1'b0;
      repeat (2000) @(negedge clk);
      check("midksa_busy", 32'(bus.rdy), 32'd0);
      check("midksa_key", 32'(bus.key), 32'h1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midksa_reset");
      @(negedge clk);
      rst_n = 1'b1;
      do_search("after_reset", 1'b0, 8'h35, 150000, 24'h000002, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
